// File: rtl/pyramid_pkg.sv
// Shared types for the pyramid decimator.
//   mode_t        : subsample (keep top-left) or box-average
//   decim_state_t : control FSM states
//   read_tag_t    : sideband that travels with each source read through the
//                   BRAM latency window
//   acc_width()   : accumulator width needed to sum a full 2^MAX x 2^MAX block
// The tag address width is sized for the default 64x64 source image.
package pyramid_pkg;
  localparam int DEF_SRC_WIDTH  = 64;
  localparam int DEF_SRC_HEIGHT = 64;
  localparam int TAG_ADDR_W     = $clog2(DEF_SRC_WIDTH * DEF_SRC_HEIGHT);

  typedef enum logic {
    MODE_SUBSAMPLE = 1'b0,
    MODE_AVERAGE   = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } decim_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  first;    // first sample of an output block
    logic                  last;     // last sample of an output block
    logic [TAG_ADDR_W-1:0] out_addr; // destination address of that block
  } read_tag_t;

  function automatic int acc_width(input int bit_depth, input int max_shift);
    return bit_depth + 2 * max_shift;
  endfunction
endpackage

// File: rtl/read_tag_pipe.sv
// Fixed-depth shift register of read tags, keeping each tag aligned with the
// pixel the BRAM returns DEPTH cycles after its address.
//   clk_in, rst_in_n : clock, async active-low clear
//   tag_i            : tag issued alongside the read address
//   tag_o            : tag aligned with the returning pixel
//   busy_o           : any stage still holds a valid tag
module read_tag_pipe
  import pyramid_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_in,
  input  logic      rst_in_n,
  input  read_tag_t tag_i,
  output read_tag_t tag_o,
  output logic      busy_o
);
  read_tag_t stg_q [DEPTH];

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      for (int i = 0; i < DEPTH; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign tag_o = stg_q[DEPTH-1];

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy_o = busy_o | stg_q[i].valid;
  end
endmodule

// File: rtl/pyramid_decimator.sv
// Builds one octave base image by decimating a BRAM-resident source image by
// 2^k, either keeping each block's top-left pixel or averaging the block.
// Build option: DECIMATOR_ROUND_EN -- average mode rounds half up instead of
// truncating.
//   clk_in, rst_in_n       : clock, async active-low reset
//   start_in/mode_in/shift_in : run request, mode and exponent k (sampled together)
//   ext_read_addr(_valid)  : source read port; ext_pixel_in returns READ_LATENCY later
//   write_addr/valid, pixel_out : destination raster write port
//   busy_out/done_out/err_out   : run status; err pulses when k is 0 or too large
module pyramid_decimator
  import pyramid_pkg::*;
#(
  parameter int BIT_DEPTH    = 8,
  parameter int SRC_WIDTH    = 64,
  parameter int SRC_HEIGHT   = 64,
  parameter int MAX_SHIFT    = 3,
  parameter int READ_LATENCY = 2,
  localparam int ADDR_W  = $clog2(SRC_WIDTH * SRC_HEIGHT),
  localparam int SHIFT_W = $clog2(MAX_SHIFT + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_in_n,
  input  logic                 start_in,
  input  logic                 mode_in,
  input  logic [SHIFT_W-1:0]   shift_in,
  output logic [ADDR_W-1:0]    ext_read_addr,
  output logic                 ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0] ext_pixel_in,
  output logic [ADDR_W-1:0]    write_addr,
  output logic                 write_valid,
  output logic [BIT_DEPTH-1:0] pixel_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 err_out
);
  localparam int LOGW  = $clog2(SRC_WIDTH);
  localparam int LOGH  = $clog2(SRC_HEIGHT);
  localparam int ACC_W = acc_width(BIT_DEPTH, MAX_SHIFT);

  decim_state_t         state_q;
  mode_t                mode_q;
  logic [SHIFT_W-1:0]   k_q;
  logic [MAX_SHIFT-1:0] bx_q, by_q, bx_d, by_d;
  logic [LOGW-1:0]      ox_q, ox_d;
  logic [LOGH-1:0]      oy_q, oy_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic                 rd_vld_q, busy_q, done_q, err_q;

  // Subsample walks a 1x1 "block", so one loop nest serves both modes.
  logic [MAX_SHIFT-1:0] bmask;
  logic [LOGW-1:0]      oxmax;
  logic [LOGH-1:0]      oymax;
  logic                 blk_first, blk_last, run_last;

  assign bmask     = (mode_q == MODE_AVERAGE) ? MAX_SHIFT'((1 << k_q) - 1) : '0;
  assign oxmax     = LOGW'((SRC_WIDTH >> k_q) - 1);
  assign oymax     = LOGH'((SRC_HEIGHT >> k_q) - 1);
  assign blk_first = (bx_q == '0) && (by_q == '0);
  assign blk_last  = (bx_q == bmask) && (by_q == bmask);
  assign run_last  = blk_last && (ox_q == oxmax) && (oy_q == oymax);

  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (bx_q != bmask) bx_d = bx_q + 1'b1;
    else begin
      bx_d = '0;
      if (by_q != bmask) by_d = by_q + 1'b1;
      else begin
        by_d = '0;
        if (ox_q != oxmax) ox_d = ox_q + 1'b1;
        else begin
          ox_d = '0;
          oy_d = oy_q + 1'b1;
        end
      end
    end
    // Fields never overlap (ox<<k < W, bx < 2^k), so OR acts as add.
    rd_addr_d = ((((ADDR_W'(oy_d) << k_q) | ADDR_W'(by_d))) << LOGW)
              | (ADDR_W'(ox_d) << k_q) | ADDR_W'(bx_d);
  end

  read_tag_t tag_in, tag_out;
  logic      pipe_busy;

  assign tag_in.valid    = rd_vld_q;
  assign tag_in.first    = blk_first;
  assign tag_in.last     = blk_last;
  assign tag_in.out_addr = TAG_ADDR_W'((ADDR_W'(oy_q) << (LOGW - k_q)) | ADDR_W'(ox_q));

  read_tag_pipe #(.DEPTH(READ_LATENCY)) u_tag_pipe (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .tag_i    (tag_in),
    .tag_o    (tag_out),
    .busy_o   (pipe_busy)
  );

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE_SUBSAMPLE;
      k_q       <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (start_in) begin
          if (shift_in == '0 || {1'b0, shift_in} > (SHIFT_W+1)'(MAX_SHIFT)) begin
            err_q <= 1'b1;
          end else begin
            state_q   <= READ;
            mode_q    <= mode_t'(mode_in);
            k_q       <= shift_in;
            bx_q      <= '0;
            by_q      <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            rd_addr_q <= '0;
            rd_vld_q  <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        READ: if (run_last) begin
          state_q  <= DRAIN;
          rd_vld_q <= 1'b0;
        end else begin
          bx_q      <= bx_d;
          by_q      <= by_d;
          ox_q      <= ox_d;
          oy_q      <= oy_d;
          rd_addr_q <= rd_addr_d;
        end
        // Pipe empties the same cycle the final write is on the port.
        DRAIN: if (!pipe_busy) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [ACC_W-1:0] acc_q, acc_total, rnd, avg_total;

  assign acc_total = tag_out.first ? ACC_W'(ext_pixel_in) : acc_q + ACC_W'(ext_pixel_in);
`ifdef DECIMATOR_ROUND_EN
  assign rnd = ACC_W'(1) << (2 * k_q - 1);
`else
  assign rnd = '0;
`endif
  assign avg_total = acc_total + rnd;

  logic                 wv_q;
  logic [ADDR_W-1:0]    wa_q;
  logic [BIT_DEPTH-1:0] px_q;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      acc_q <= '0;
      wv_q  <= 1'b0;
      wa_q  <= '0;
      px_q  <= '0;
    end else begin
      wv_q <= 1'b0;
      if (tag_out.valid) begin
        acc_q <= acc_total;
        if (tag_out.last) begin
          wv_q <= 1'b1;
          wa_q <= ADDR_W'(tag_out.out_addr);
          px_q <= (mode_q == MODE_AVERAGE) ? BIT_DEPTH'(avg_total >> (2 * k_q)) : ext_pixel_in;
        end
      end
    end
  end

  assign ext_read_addr       = rd_addr_q;
  assign ext_read_addr_valid = rd_vld_q;
  assign write_addr          = wa_q;
  assign write_valid         = wv_q;
  assign pixel_out           = px_q;
  assign busy_out            = busy_q;
  assign done_out            = done_q;
  assign err_out             = err_q;
endmodule
